// File: rtl/led_blink_bank.sv
// Bank of NCHAN LED drivers with per-channel OFF/ON/BLINK/FOLLOW modes and run-time retuning.
// Optional feature macro: LED_PWM_EN adds a shared PWM counter and per-channel brightness (cfg_duty).
module led_blink_bank #(
  parameter int unsigned NCHAN    = 8,
  parameter int unsigned CNT_W    = 27,
  parameter logic [1:0]  MODE_RST = 2'b10,
  parameter int unsigned HALF_RST = 50000000,
  parameter int unsigned PWM_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [$clog2(NCHAN):0]  cfg_chan,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_half,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]        cfg_duty,
`endif
  input  logic                    sync_all,
  input  logic [NCHAN-1:0]        direct_in,
  output logic [NCHAN-1:0]        led
);

  localparam int unsigned CHAN_W = $clog2(NCHAN) + 1;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_FOLLOW = 2'b11
  } mode_e;

  mode_e            mode_q [NCHAN];
  logic [CNT_W-1:0] half_q [NCHAN];
  logic [CNT_W-1:0] cnt_q  [NCHAN];
  logic [CNT_W-1:0] term_c [NCHAN];
  logic [NCHAN-1:0] ph_q;
  logic [NCHAN-1:0] sync1_q;
  logic [NCHAN-1:0] sync2_q;
  logic [NCHAN-1:0] wr_c;
  logic [NCHAN-1:0] restart_c;
  logic [NCHAN-1:0] lit_c;
  logic [NCHAN-1:0] gate_c;

  // Per-channel write decode, terminal count (half==0 acts as 1) and lit level.
  always_comb begin
    wr_c      = '0;
    restart_c = '0;
    lit_c     = '0;
    for (int i = 0; i < NCHAN; i++) begin
      wr_c[i]      = cfg_we && (cfg_chan == CHAN_W'(i));
      restart_c[i] = wr_c[i] || sync_all || (mode_q[i] != MODE_BLINK);
      term_c[i]    = (half_q[i] == '0) ? '0 : half_q[i] - CNT_W'(1);
      case (mode_q[i])
        MODE_OFF:    lit_c[i] = 1'b0;
        MODE_ON:     lit_c[i] = 1'b1;
        MODE_BLINK:  lit_c[i] = ph_q[i];
        MODE_FOLLOW: lit_c[i] = sync2_q[i];
        default:     lit_c[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] cnt_pwm_q;
  logic [PWM_W-1:0] duty_q [NCHAN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_pwm_q <= '0;
      for (int i = 0; i < NCHAN; i++) duty_q[i] <= '1;
    end else begin
      cnt_pwm_q <= cnt_pwm_q + PWM_W'(1);
      for (int i = 0; i < NCHAN; i++) begin
        if (wr_c[i]) duty_q[i] <= cfg_duty;
      end
    end
  end

  // Full duty bypasses the compare so all-ones means constantly lit.
  always_comb begin
    gate_c = '0;
    for (int i = 0; i < NCHAN; i++) begin
      gate_c[i] = (duty_q[i] == '1) || (cnt_pwm_q < duty_q[i]);
    end
  end
`else
  logic [PWM_W-1:0] unused_pwm;
  assign unused_pwm = '0;
  assign gate_c     = '1;
`endif

  // Synchronisers, LED flops and per-channel blink state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ph_q    <= '0;
      led     <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        mode_q[i] <= mode_e'(MODE_RST);
        half_q[i] <= CNT_W'(HALF_RST);
        cnt_q[i]  <= '0;
      end
    end else begin
      sync1_q <= direct_in;
      sync2_q <= sync1_q;
      led     <= lit_c & gate_c;
      for (int i = 0; i < NCHAN; i++) begin
        if (wr_c[i]) begin
          mode_q[i] <= mode_e'(cfg_mode);
          half_q[i] <= cfg_half;
        end
        // A restart on the terminal-count edge suppresses that toggle.
        if (restart_c[i]) begin
          cnt_q[i] <= '0;
          ph_q[i]  <= 1'b0;
        end else if (cnt_q[i] == term_c[i]) begin
          cnt_q[i] <= '0;
          ph_q[i]  <= ~ph_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule
